// File: rtl/pkt_guard.sv
// pkt_guard: store-and-forward Avalon-ST qualifier.
// Buffers one packet and forwards it only if it is well framed and 1..MAX_PKT_LEN words long.
module pkt_guard #(
    parameter int DWIDTH      = 16,
    parameter int MAX_PKT_LEN = 1000,
    parameter int CWIDTH      = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic [CWIDTH-1:0] drop_cnt_o
);
    localparam int AWIDTH = $clog2(MAX_PKT_LEN) + 1;
    localparam int IWIDTH = $clog2(MAX_PKT_LEN);
    localparam logic [AWIDTH-1:0] MAX_LEN = AWIDTH'(MAX_PKT_LEN);

    typedef enum logic [1:0] {IDLE, RECV, DROP, SEND} state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_len;
    logic [AWIDTH-1:0] r_raddr;
    logic              r_snk_rdy;
    logic [DWIDTH-1:0] r_mem [MAX_PKT_LEN];
    logic [DWIDTH-1:0] r_rdata;
    logic              r_rv;
    logic              r_rsop;
    logic              r_reop;
    logic              r_src_valid;
    logic              r_src_sop;
    logic              r_src_eop;
    logic [DWIDTH-1:0] r_src_data;
    logic [CWIDTH-1:0] r_drop_cnt;

    logic w_beat, w_sop, w_eop, w_full, w_we, w_drop, w_to_send;
    logic w_b_free, w_a_move, w_rd, w_src_eop_xfer;

    assign w_beat    = snk_valid_i && r_snk_rdy;
    assign w_sop     = w_beat && snk_startofpacket_i;
    assign w_eop     = w_beat && snk_endofpacket_i;
    assign w_full    = r_len == MAX_LEN;
    assign w_we      = w_sop || (w_beat && r_state == RECV && !w_full);
    assign w_drop    = (r_state == RECV && (w_sop || (w_eop && w_full))) ||
                       (r_state == DROP && (w_sop || w_eop));
    assign w_to_send = w_eop && (w_sop || (r_state == RECV && !w_full));

    // Two-stage read: RAM output register feeds the output register, so one word moves per cycle
    assign w_b_free       = !r_src_valid || src_ready_i;
    assign w_a_move       = r_rv && w_b_free;
    assign w_rd           = r_state == SEND && r_raddr < r_len && (!r_rv || w_a_move);
    assign w_src_eop_xfer = r_src_valid && src_ready_i && r_src_eop;

    always_ff @(posedge clk_i) begin
        if (w_we)
            r_mem[w_sop ? '0 : r_len[IWIDTH-1:0]] <= snk_data_i;
        if (w_rd)
            r_rdata <= r_mem[r_raddr[IWIDTH-1:0]];
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_raddr     <= '0;
            r_snk_rdy   <= 1'b0;
            r_rv        <= 1'b0;
            r_rsop      <= 1'b0;
            r_reop      <= 1'b0;
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
            r_src_data  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_drop && !(&r_drop_cnt))
                r_drop_cnt <= r_drop_cnt + CWIDTH'(1);
            // Ready stays low for one cycle after SEND ends, then IDLE raises it
            if (r_state == SEND) begin
                r_snk_rdy <= 1'b0;
                if (w_src_eop_xfer)
                    r_state <= IDLE;
            end else if (w_to_send) begin
                r_state   <= SEND;
                r_snk_rdy <= 1'b0;
                r_len     <= w_sop ? AWIDTH'(1) : r_len + AWIDTH'(1);
            end else begin
                r_snk_rdy <= 1'b1;
                if (w_sop) begin
                    r_state <= RECV;
                    r_len   <= AWIDTH'(1);
                end else if (w_beat && r_state == RECV) begin
                    if (w_full)
                        r_state <= w_eop ? IDLE : DROP;
                    else
                        r_len <= r_len + AWIDTH'(1);
                end else if (w_eop && r_state == DROP) begin
                    r_state <= IDLE;
                end
            end
            if (w_to_send)
                r_raddr <= '0;
            else if (w_rd)
                r_raddr <= r_raddr + AWIDTH'(1);
            if (w_rd) begin
                r_rv   <= 1'b1;
                r_rsop <= r_raddr == '0;
                r_reop <= r_raddr == r_len - AWIDTH'(1);
            end else if (w_a_move) begin
                r_rv <= 1'b0;
            end
            if (w_a_move) begin
                r_src_valid <= 1'b1;
                r_src_data  <= r_rdata;
                r_src_sop   <= r_rsop;
                r_src_eop   <= r_reop;
            end else if (src_ready_i) begin
                r_src_valid <= 1'b0;
            end
        end
    end

    assign snk_ready_o         = r_snk_rdy;
    assign src_valid_o         = r_src_valid;
    assign src_data_o          = r_src_data;
    assign src_startofpacket_o = r_src_sop;
    assign src_endofpacket_o   = r_src_eop;
    assign drop_cnt_o          = r_drop_cnt;
endmodule

// File: tb/tb_pkt_guard.sv
// tb_pkt_guard: cycle-exact vector table plus randomized traffic scored against a packet-level model.
module tb_pkt_guard;
    localparam int MAXL = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [15:0]   snk_data = '0;
    logic          snk_sop = 1'b0;
    logic          snk_eop = 1'b0;
    logic          snk_valid = 1'b0;
    logic          snk_ready;
    logic [15:0]   src_data;
    logic          src_sop;
    logic          src_eop;
    logic          src_valid;
    logic          src_ready = 1'b0;
    logic [CW-1:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    int m_drop = 0;
    bit auto_rdy = 0;
    int rdy_pct = 100;

    typedef struct packed {logic [15:0] d; logic s; logic e;} word_t;
    word_t       exp_q[$];
    logic [15:0] cur[$];
    bit          in_pkt = 0;
    logic        p_v = 0, p_r = 0, p_s = 0, p_e = 0;
    logic [15:0] p_d = '0;

    typedef struct packed {
        logic v, s, e; logic [15:0] d; logic sr;
        logic x_rdy, x_v, x_s, x_e; logic [15:0] x_d;
    } vec_t;
    vec_t tv[14];

    pkt_guard #(.DWIDTH(16), .MAX_PKT_LEN(MAXL), .CWIDTH(CW)) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
        .snk_valid_i(snk_valid), .snk_ready_o(snk_ready),
        .src_data_o(src_data), .src_startofpacket_o(src_sop), .src_endofpacket_o(src_eop),
        .src_valid_o(src_valid), .src_ready_i(src_ready), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, s, e, input logic [15:0] d, input logic sr,
                                input logic x_rdy, x_v, x_s, x_e, input logic [15:0] x_d);
        return '{v, s, e, d, sr, x_rdy, x_v, x_s, x_e, x_d};
    endfunction

    // Packet-level reference: accepted sink beats are grouped into packets and judged on length
    always @(negedge clk) begin
        if (!arst_n) begin
            cur.delete();
            exp_q.delete();
            in_pkt = 0;
            m_drop = 0;
            p_v = 0;
        end else begin
            if (snk_valid && snk_ready) begin
                if (snk_sop) begin
                    if (in_pkt) m_drop++;
                    cur.delete();
                    in_pkt = 1;
                end
                if (in_pkt) begin
                    cur.push_back(snk_data);
                    if (snk_eop) begin
                        if (cur.size() <= MAXL)
                            foreach (cur[i]) exp_q.push_back('{cur[i], i == 0, i == cur.size() - 1});
                        else
                            m_drop++;
                        cur.delete();
                        in_pkt = 0;
                    end
                end
            end
            if (p_v && !p_r) begin
                chk("hold_valid", src_valid, 1);
                if (src_valid) begin
                    chk("hold_data", src_data, p_d);
                    chk("hold_sop", src_sop, p_s);
                    chk("hold_eop", src_eop, p_e);
                end
            end
            if (src_valid && src_ready) begin
                word_t w;
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("extra_word", src_data, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("out_data", src_data, w.d);
                    chk("out_sop", src_sop, w.s);
                    chk("out_eop", src_eop, w.e);
                end
            end
            p_v = src_valid; p_r = src_ready; p_d = src_data; p_s = src_sop; p_e = src_eop;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (auto_rdy) src_ready = $urandom_range(0, 99) < rdy_pct;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        arst_n = 0;
        snk_valid = 0;
        #1 chk("rst_rdy_low", snk_ready, 0);
        chk("rst_valid_low", src_valid, 0);
        repeat (3) @(posedge clk);
        #3 arst_n = 1;
        @(negedge clk);
        chk("rst_rdy_before_edge", snk_ready, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        chk("rst_rdy_after_edge", snk_ready, 1);
    endtask

    task automatic put(input logic [15:0] d, input logic s, input logic e);
        int t = 0;
        snk_valid = 1; snk_data = d; snk_sop = s; snk_eop = e;
        @(negedge clk);
        while (!snk_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!snk_ready) chk("put_timeout", 0, 1);
        @(posedge clk); #1;
        snk_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || src_valid) && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1 chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        logic [15:0] bp[4];
        do_reset();

        // Pass-through 5,3,9,1,7 with exact latency; a beat offered during SEND must be ignored
        tv[0]  = mk(1, 1, 0, 16'd5, 1,  1, 0, 0, 0, 0);
        tv[1]  = mk(1, 0, 0, 16'd3, 1,  1, 0, 0, 0, 0);
        tv[2]  = mk(1, 0, 0, 16'd9, 1,  1, 0, 0, 0, 0);
        tv[3]  = mk(1, 0, 0, 16'd1, 1,  1, 0, 0, 0, 0);
        tv[4]  = mk(1, 0, 1, 16'd7, 1,  1, 0, 0, 0, 0);
        tv[5]  = mk(1, 1, 1, 16'hEE, 1, 0, 0, 0, 0, 0);
        tv[6]  = mk(0, 0, 0, 16'd0, 1,  0, 0, 0, 0, 0);
        tv[7]  = mk(0, 0, 0, 16'd0, 1,  0, 1, 1, 0, 16'd5);
        tv[8]  = mk(0, 0, 0, 16'd0, 1,  0, 1, 0, 0, 16'd3);
        tv[9]  = mk(0, 0, 0, 16'd0, 1,  0, 1, 0, 0, 16'd9);
        tv[10] = mk(0, 0, 0, 16'd0, 1,  0, 1, 0, 0, 16'd1);
        tv[11] = mk(0, 0, 0, 16'd0, 1,  0, 1, 0, 1, 16'd7);
        tv[12] = mk(0, 0, 0, 16'd0, 1,  0, 0, 0, 0, 0);
        tv[13] = mk(0, 0, 0, 16'd0, 1,  1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            snk_valid = tv[i].v; snk_sop = tv[i].s; snk_eop = tv[i].e;
            snk_data = tv[i].d; src_ready = tv[i].sr;
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", i), snk_ready, tv[i].x_rdy);
            chk($sformatf("vec%0d_valid", i), src_valid, tv[i].x_v);
            chk($sformatf("vec%0d_drop", i), drop_cnt, 0);
            if (tv[i].x_v) begin
                chk($sformatf("vec%0d_data", i), src_data, tv[i].x_d);
                chk($sformatf("vec%0d_sop", i), src_sop, tv[i].x_s);
                chk($sformatf("vec%0d_eop", i), src_eop, tv[i].x_e);
            end
            @(posedge clk); #1;
        end
        snk_valid = 0;
        auto_rdy = 1;
        rdy_pct = 100;

        // Length boundary: MAXL+1 words dropped, MAXL words forwarded
        do_reset();
        base = n_out;
        for (int i = 0; i < MAXL + 1; i++) put(16'(16'h100 + i), i == 0, i == MAXL);
        for (int i = 0; i < MAXL; i++) put(16'(i + 1), i == 0, i == MAXL - 1);
        drain();
        chk("len_drop", drop_cnt, 1);
        chk("len_words", n_out - base, MAXL);

        // Restart mid-packet, then orphans in IDLE
        do_reset();
        base = n_out;
        put(16'hA, 1, 0); put(16'hB, 0, 0);
        put(16'h1, 1, 0); put(16'h2, 0, 0); put(16'h3, 0, 1);
        drain();
        chk("restart_drop", drop_cnt, 1);
        chk("restart_words", n_out - base, 3);
        put(16'h55, 0, 0); put(16'h66, 0, 1);
        repeat (3) @(posedge clk); #1;
        chk("orphan_drop", drop_cnt, 1);
        chk("orphan_words", n_out - base, 3);

        // Backpressure: ready must stay low while the packet is being sent
        do_reset();
        rdy_pct = 50;
        base = n_out;
        foreach (bp[i]) bp[i] = 16'($urandom);
        foreach (bp[i]) put(bp[i], i == 0, i == 3);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
            chk("bp_snk_rdy_low", snk_ready, 0);
            @(posedge clk); #1;
        end
        drain();
        chk("bp_words", n_out - base, 4);

        // Single-word packet, cycle by cycle
        rdy_pct = 100;
        do_reset();
        put(16'h1234, 1, 1);
        @(negedge clk); chk("one_rdy_n", snk_ready, 0); chk("one_valid_n", src_valid, 0);
        @(negedge clk); chk("one_valid_n1", src_valid, 0);
        @(negedge clk);
        chk("one_valid_n2", src_valid, 1); chk("one_data", src_data, 16'h1234);
        chk("one_sop", src_sop, 1); chk("one_eop", src_eop, 1); chk("one_rdy_n2", snk_ready, 0);
        @(negedge clk); chk("one_valid_m", src_valid, 0); chk("one_rdy_m", snk_ready, 0);
        @(negedge clk); chk("one_rdy_m1", snk_ready, 1);
        @(posedge clk); #1;

        // Reset during SEND after two of six words
        do_reset();
        base = n_out;
        for (int i = 0; i < 6; i++) put(16'(16'h40 + i), i == 0, i == 5);
        for (int t = 0; t < 100 && n_out - base < 2; t++) @(posedge clk);
        #1 arst_n = 0;
        #1 chk("rst_send_valid", src_valid, 0);
        chk("rst_send_words", n_out - base, 2);
        do_reset();
        base = n_out;
        put(16'h71, 1, 0); put(16'h72, 0, 0); put(16'h73, 0, 1);
        drain();
        chk("post_rst_words", n_out - base, 3);

        // Counter saturation: repeated restarts
        do_reset();
        for (int i = 0; i < CMAX + 4; i++) put(16'(i), 1, 0);
        chk("drop_sat", drop_cnt, CMAX);

        // Randomized traffic: orphans, truncated packets, oversize and legal packets
        do_reset();
        rdy_pct = 60;
        for (int p = 0; p < 40; p++) begin
            int kind = $urandom_range(0, 9);
            int len  = $urandom_range(1, MAXL + 3);
            if (kind == 0) begin
                put(16'($urandom), 0, 1'($urandom_range(0, 1)));
            end else begin
                for (int i = 0; i < len; i++) begin
                    put(16'($urandom), i == 0, kind != 1 && i == len - 1);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
        drain();
        chk("rnd_drop", drop_cnt, m_drop > CMAX ? CMAX : m_drop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
